// File: rtl/ehl_dfi_cmd_sched.sv
// ehl_dfi_cmd_sched: read/write arbiter feeding the DFI command slot, with turnaround gaps,
// a starvation limit and write-data credit tracking against the PHY write-data FIFO.
// Latency: grant in cycle N (combinational), cmd_valid/cmd_we/cmd_addr registered in N+1.
// Backpressure: cmd_ready=0 holds the output register and blocks all grants; gap counters keep running.
// Ports:
//   clk, reset_n                 controller clock, async active-low reset
//   rd_req/rd_addr/rd_gnt        read requester (request held until grant)
//   wr_req/wr_addr/wr_gnt        write requester (request held until grant)
//   wr_done                      PHY consumed one write burst (returns one credit)
//   cmd_valid/cmd_we/cmd_addr    registered command to the DFI pipeline, cmd_ready accepts
//   credits, credit_err          free write credits, sticky credit-return overflow flag
module ehl_dfi_cmd_sched #(
  parameter int unsigned T_WTR        = 4,
  parameter int unsigned T_RTW        = 6,
  parameter int unsigned WR_CREDITS   = 16,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned ADDR_W       = 28
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic              wr_gnt,
  input  logic              wr_done,
  output logic              cmd_valid,
  output logic              cmd_we,
  output logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_ready,
  output logic [4:0]        credits,
  output logic              credit_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RD_RUN = 2'd1,
    ST_WR_RUN = 2'd2
  } state_t;

  localparam logic [4:0] CRED_MAX = 5'(WR_CREDITS);
  localparam logic [7:0] STARVE   = 8'(STARVE_LIMIT);
  // The capture cycle itself is the first cycle of the gap, so the counter is
  // loaded one short: a capture at N makes the other side eligible at N+T.
  localparam logic [3:0] WTR_LOAD = 4'(T_WTR - 1);
  localparam logic [3:0] RTW_LOAD = 4'(T_RTW - 1);

  state_t            state_q, state_d;
  logic [3:0]        wtr_cnt_q, wtr_cnt_d;
  logic [3:0]        rtw_cnt_q, rtw_cnt_d;
  logic [7:0]        streak_q, streak_d;
  logic [4:0]        credits_q, credits_d;
  logic              credit_err_q, credit_err_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;

  logic rd_elig, wr_elig;
  logic rd_sel, wr_sel;
  logic other_req, leave_dir;
  logic rd_gnt_int, wr_gnt_int;

  assign rd_elig = rd_req && (wtr_cnt_q == 4'd0);
  assign wr_elig = wr_req && (credits_q != 5'd0) && (rtw_cnt_q == 4'd0);

  // Direction selection. While leaving a direction, only the new side may be
  // granted; the state flips on that first grant, not when the switch decision is made.
  always_comb begin
    rd_sel    = 1'b0;
    wr_sel    = 1'b0;
    other_req = 1'b0;
    leave_dir = 1'b0;
    case (state_q)
      ST_RD_RUN: begin
        other_req = wr_req;
        leave_dir = !rd_req || (wr_req && (streak_q >= STARVE));
        if (leave_dir) wr_sel = wr_elig;
        else           rd_sel = rd_elig;
      end
      ST_WR_RUN: begin
        other_req = rd_req;
        leave_dir = !wr_req || (rd_req && (streak_q >= STARVE));
        if (leave_dir) rd_sel = rd_elig;
        else           wr_sel = wr_elig;
      end
      default: begin
        rd_sel = rd_elig;
        wr_sel = !rd_elig && wr_elig;
      end
    endcase
  end

  // A stalled output register blocks capture; reset forces grants low.
  assign rd_gnt_int = reset_n && cmd_ready && rd_sel;
  assign wr_gnt_int = reset_n && cmd_ready && wr_sel;
  assign rd_gnt     = rd_gnt_int;
  assign wr_gnt     = wr_gnt_int;

  always_comb begin
    state_d      = state_q;
    streak_d     = streak_q;
    wtr_cnt_d    = (wtr_cnt_q != 4'd0) ? wtr_cnt_q - 4'd1 : 4'd0;
    rtw_cnt_d    = (rtw_cnt_q != 4'd0) ? rtw_cnt_q - 4'd1 : 4'd0;
    credits_d    = credits_q;
    credit_err_d = credit_err_q || (wr_done && (credits_q == CRED_MAX));
    cmd_valid_d  = cmd_valid_q;
    cmd_we_d     = cmd_we_q;
    cmd_addr_d   = cmd_addr_q;

    // Streak counts consecutive same-direction grants only while the other side waits;
    // the first grant after a direction change counts as one.
    if (rd_gnt_int) begin
      state_d   = ST_RD_RUN;
      rtw_cnt_d = RTW_LOAD;
      if (!wr_req)                  streak_d = 8'd0;
      else if (state_q == ST_RD_RUN) streak_d = streak_q + 8'd1;
      else                          streak_d = 8'd1;
    end else if (wr_gnt_int) begin
      state_d   = ST_WR_RUN;
      wtr_cnt_d = WTR_LOAD;
      if (!rd_req)                  streak_d = 8'd0;
      else if (state_q == ST_WR_RUN) streak_d = streak_q + 8'd1;
      else                          streak_d = 8'd1;
    end else if (!other_req) begin
      streak_d = 8'd0;
    end

    // A grant and a returned burst in the same cycle cancel out; a return while
    // the FIFO is already empty is flagged and otherwise ignored.
    if (wr_gnt_int && !wr_done) begin
      credits_d = credits_q - 5'd1;
    end else if (!wr_gnt_int && wr_done && (credits_q != CRED_MAX)) begin
      credits_d = credits_q + 5'd1;
    end

    if (rd_gnt_int || wr_gnt_int) begin
      cmd_valid_d = 1'b1;
      cmd_we_d    = wr_gnt_int;
      cmd_addr_d  = wr_gnt_int ? wr_addr : rd_addr;
    end else if (cmd_ready) begin
      cmd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      wtr_cnt_q    <= 4'd0;
      rtw_cnt_q    <= 4'd0;
      streak_q     <= 8'd0;
      credits_q    <= CRED_MAX;
      credit_err_q <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_we_q     <= 1'b0;
      cmd_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      wtr_cnt_q    <= wtr_cnt_d;
      rtw_cnt_q    <= rtw_cnt_d;
      streak_q     <= streak_d;
      credits_q    <= credits_d;
      credit_err_q <= credit_err_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_we_q     <= cmd_we_d;
      cmd_addr_q   <= cmd_addr_d;
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_we     = cmd_we_q;
  assign cmd_addr   = cmd_addr_q;
  assign credits    = credits_q;
  assign credit_err = credit_err_q;

endmodule

// File: tb/tb_ehl_dfi_cmd_sched.sv
// tb_ehl_dfi_cmd_sched: directed scenarios plus randomized traffic for ehl_dfi_cmd_sched,
// checked every cycle against a timestamp-based reference model of the arbitration rules.
// Ports: none (top-level bench); drives the scheduler and prints one summary line.
module tb_ehl_dfi_cmd_sched;

  localparam int ADDR_W       = 28;
  localparam int T_WTR        = 4;
  localparam int T_RTW        = 6;
  localparam int WR_CREDITS   = 16;
  localparam int STARVE_LIMIT = 8;

  localparam int DIR_NONE = 0;
  localparam int DIR_RD   = 1;
  localparam int DIR_WR   = 2;

  logic              clk;
  logic              reset_n;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_gnt;
  logic              wr_done;
  logic              cmd_valid;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_ready;
  logic [4:0]        credits;
  logic              credit_err;

  ehl_dfi_cmd_sched #(
    .T_WTR       (T_WTR),
    .T_RTW       (T_RTW),
    .WR_CREDITS  (WR_CREDITS),
    .STARVE_LIMIT(STARVE_LIMIT),
    .ADDR_W      (ADDR_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_gnt    (rd_gnt),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_gnt    (wr_gnt),
    .wr_done   (wr_done),
    .cmd_valid (cmd_valid),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_ready (cmd_ready),
    .credits   (credits),
    .credit_err(credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: gaps measured from capture timestamps, credits as a plain count.
  int                cyc;
  int                last_rd_cap, last_wr_cap;
  int                m_credits, m_dir, m_streak;
  bit                m_err, m_vld, m_we;
  logic [ADDR_W-1:0] m_addr;
  bit                e_rd, e_wr;
  bit                o_rd, o_wr;
  bit                s_rd_req, s_wr_req, s_wr_done, s_ready;
  logic [ADDR_W-1:0] s_rd_addr, s_wr_addr;

  task automatic model_reset();
    cyc         = 0;
    last_rd_cap = -1000;
    last_wr_cap = -1000;
    m_credits   = WR_CREDITS;
    m_dir       = DIR_NONE;
    m_streak    = 0;
    m_err       = 1'b0;
    m_vld       = 1'b0;
    m_we        = 1'b0;
    m_addr      = '0;
    e_rd        = 1'b0;
    e_wr        = 1'b0;
  endtask

  task automatic model_eval_check();
    bit rd_ok, wr_ok, leave;
    s_rd_req  = rd_req;
    s_wr_req  = wr_req;
    s_wr_done = wr_done;
    s_ready   = cmd_ready;
    s_rd_addr = rd_addr;
    s_wr_addr = wr_addr;
    rd_ok = s_rd_req && ((cyc - last_wr_cap) >= T_WTR);
    wr_ok = s_wr_req && (m_credits > 0) && ((cyc - last_rd_cap) >= T_RTW);
    e_rd  = 1'b0;
    e_wr  = 1'b0;
    if (s_ready) begin
      if (m_dir == DIR_NONE) begin
        if (rd_ok)      e_rd = 1'b1;
        else if (wr_ok) e_wr = 1'b1;
      end else if (m_dir == DIR_RD) begin
        leave = !s_rd_req || (s_wr_req && m_streak >= STARVE_LIMIT);
        if (leave) e_wr = wr_ok;
        else       e_rd = rd_ok;
      end else begin
        leave = !s_wr_req || (s_rd_req && m_streak >= STARVE_LIMIT);
        if (leave) e_rd = rd_ok;
        else       e_wr = wr_ok;
      end
    end
    o_rd = rd_gnt;
    o_wr = wr_gnt;
    chk_eq("rd_gnt", rd_gnt, e_rd);
    chk_eq("wr_gnt", wr_gnt, e_wr);
    chk_eq("cmd_valid", cmd_valid, m_vld);
    chk_eq("credits", credits, m_credits);
    chk_eq("credit_err", credit_err, m_err);
    if (m_vld) begin
      chk_eq("cmd_we", cmd_we, m_we);
      chk_eq("cmd_addr", cmd_addr, m_addr);
    end
  endtask

  task automatic model_update();
    if (s_wr_done && m_credits == WR_CREDITS) m_err = 1'b1;
    if (e_wr && !s_wr_done) m_credits--;
    else if (!e_wr && s_wr_done && m_credits < WR_CREDITS) m_credits++;
    if (e_rd) begin
      m_streak    = !s_wr_req ? 0 : (m_dir == DIR_RD ? m_streak + 1 : 1);
      m_dir       = DIR_RD;
      last_rd_cap = cyc;
      m_vld       = 1'b1;
      m_we        = 1'b0;
      m_addr      = s_rd_addr;
    end else if (e_wr) begin
      m_streak    = !s_rd_req ? 0 : (m_dir == DIR_WR ? m_streak + 1 : 1);
      m_dir       = DIR_WR;
      last_wr_cap = cyc;
      m_vld       = 1'b1;
      m_we        = 1'b1;
      m_addr      = s_wr_addr;
    end else begin
      if ((m_dir == DIR_RD && !s_wr_req) || (m_dir == DIR_WR && !s_rd_req)) m_streak = 0;
      if (s_ready) m_vld = 1'b0;
    end
    cyc++;
  endtask

  // One clock: check at the falling edge, advance the model after the rising edge,
  // and present a fresh address to any requester that was just granted.
  task automatic cycle();
    @(negedge clk);
    model_eval_check();
    @(posedge clk);
    #1;
    model_update();
    if (e_rd) rd_addr = ADDR_W'($urandom);
    if (e_wr) wr_addr = ADDR_W'($urandom);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    rd_req    = 1'b1;
    wr_req    = 1'b1;
    cmd_ready = 1'b1;
    wr_done   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst_rd_gnt", rd_gnt, 0);
    chk_eq("rst_wr_gnt", wr_gnt, 0);
    chk_eq("rst_cmd_valid", cmd_valid, 0);
    chk_eq("rst_cmd_we", cmd_we, 0);
    chk_eq("rst_cmd_addr", cmd_addr, 0);
    chk_eq("rst_credits", credits, WR_CREDITS);
    chk_eq("rst_credit_err", credit_err, 0);
    rd_req  = 1'b0;
    wr_req  = 1'b0;
    rd_addr = ADDR_W'($urandom);
    wr_addr = ADDR_W'($urandom);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int first_rd, first_wr, last_rd, n_rd, n_wr;
    logic [ADDR_W-1:0] hold_addr;

    reset_n   = 1'b0;
    rd_req    = 1'b0;
    wr_req    = 1'b0;
    wr_done   = 1'b0;
    cmd_ready = 1'b0;
    rd_addr   = '0;
    wr_addr   = '0;
    model_reset();

    // Both sides held: reads first, starvation limit, then read-to-write gap.
    do_reset();
    rd_req = 1'b1; wr_req = 1'b1; cmd_ready = 1'b1;
    first_rd = -1; first_wr = -1; last_rd = -1; n_rd = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (o_rd && first_rd < 0) first_rd = i;
      if (o_rd && first_wr < 0) begin n_rd++; last_rd = i; end
      if (o_wr && first_wr < 0) first_wr = i;
    end
    chk_eq("t1_first_rd_cycle", first_rd, 0);
    chk_eq("t1_reads_before_wr", n_rd, STARVE_LIMIT);
    chk_eq("t1_rtw_gap", first_wr - last_rd, T_RTW);

    // Writes only: credit exhaustion, then one returned burst gives one grant.
    do_reset();
    wr_req = 1'b1;
    n_wr = 0;
    for (int i = 0; i < 25; i++) begin
      cycle();
      if (o_wr) n_wr++;
    end
    chk_eq("t2_wr_grants", n_wr, WR_CREDITS);
    chk_eq("t2_credits_empty", credits, 0);
    wr_done = 1'b1;
    cycle();
    chk_eq("t2_no_gnt_on_done", o_wr, 0);
    wr_done = 1'b0;
    cycle();
    chk_eq("t2_gnt_after_done", o_wr, 1);
    cycle();
    chk_eq("t2_stall_again", o_wr, 0);

    // Simultaneous grant/return, then overflow of credit returns.
    do_reset();
    wr_req = 1'b1;
    repeat (11) cycle();
    chk_eq("t3_credits_5", credits, 5);
    wr_done = 1'b1;
    cycle();
    chk_eq("t3_gnt_with_done", o_wr, 1);
    chk_eq("t3_credits_hold", credits, 5);
    wr_req = 1'b0;
    repeat (11) cycle();
    chk_eq("t3_credits_full", credits, WR_CREDITS);
    chk_eq("t3_no_err_yet", credit_err, 0);
    cycle();
    wr_done = 1'b0;
    chk_eq("t3_err_set", credit_err, 1);
    chk_eq("t3_credits_sat", credits, WR_CREDITS);
    cycle();
    chk_eq("t3_err_sticky", credit_err, 1);

    // Write at cycle 10, then reads only: write-to-read gap.
    do_reset();
    repeat (10) cycle();
    wr_req = 1'b1;
    cycle();
    chk_eq("t4_wr_at_10", o_wr, 1);
    wr_req = 1'b0; rd_req = 1'b1;
    first_rd = -1;
    for (int i = 11; i < 24; i++) begin
      cycle();
      if (o_rd && first_rd < 0) first_rd = i;
    end
    chk_eq("t4_first_rd", first_rd, 10 + T_WTR);

    // Output stall: no grants, stable output, then one grant per cycle.
    do_reset();
    rd_req = 1'b1; wr_req = 1'b1;
    repeat (3) cycle();
    hold_addr = m_addr;
    cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk_eq("t5_no_gnt", o_rd | o_wr, 0);
      chk_eq("t5_vld_held", cmd_valid, 1);
      chk_eq("t5_we_held", cmd_we, 0);
      chk_eq("t5_addr_held", cmd_addr, hold_addr);
    end
    cmd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk_eq("t5_resume", o_rd, 1);
    end

    // Reset while a command is pending.
    do_reset();
    wr_req = 1'b1;
    repeat (13) cycle();
    chk_eq("t6_pre_credits", credits, 3);
    chk_eq("t6_pre_vld", cmd_valid, 1);
    reset_n = 1'b0;
    #1;
    chk_eq("t6_rst_vld", cmd_valid, 0);
    chk_eq("t6_rst_credits", credits, WR_CREDITS);
    do_reset();
    rd_req = 1'b1; wr_req = 1'b1;
    cycle();
    chk_eq("t6_tie_rd", o_rd, 1);
    chk_eq("t6_tie_wr", o_wr, 0);

    // Randomized traffic with backpressure and burst returns.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      if (!rd_req || e_rd) rd_req = ($urandom_range(0, 99) < 55);
      if (!wr_req || e_wr) wr_req = ($urandom_range(0, 99) < 55);
      cmd_ready = ($urandom_range(0, 99) < 80);
      if (m_credits < WR_CREDITS) wr_done = ($urandom_range(0, 99) < 35);
      else                        wr_done = ($urandom_range(0, 99) < 3);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
